// File: rtl/bcd_disp_pkg.sv
// ---------------------------------------------------------------------------
// bcd_disp_pkg
// Shared declarations for the BCD scan driver and its double-dabble core.
//   dd_state_t : conversion FSM state (IDLE, CONVERT, COMMIT)
//   BCD_DARK   : code sent to the 7-segment decoder when a panel is in
//                overflow; the decoder renders it dark
//   clog2      : minimum counter width (never less than 1) for a count range
// ---------------------------------------------------------------------------
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } dd_state_t;

  localparam logic [3:0] BCD_DARK = 4'hF;

  // Width needed to hold values 0..value-1; at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// ---------------------------------------------------------------------------
// bin2bcd_dd
// Sequential shift-add-3 (double dabble) binary to BCD converter.
// A start pulse in IDLE captures the binary value; the core then spends
// exactly BIN_W cycles in CONVERT and one cycle in COMMIT, during which
// done=1 and bcd_acc holds the final (DIGITS+1)-digit result.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : capture request, honoured only in IDLE
//   bin_value : unsigned binary input
//   busy      : 1 in CONVERT and COMMIT
//   done      : 1 in COMMIT (result valid on bcd_acc)
//   bcd_acc   : BCD accumulator, digit 0 in bits [3:0], extra top digit last
// ---------------------------------------------------------------------------
module bin2bcd_dd
  import bcd_disp_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BIN_W-1:0]           bin_value,
  output logic                       busy,
  output logic                       done,
  output logic [(DIGITS+1)*4-1:0]    bcd_acc
);

  localparam int ACC_W = (DIGITS + 1) * 4;
  localparam int CNT_W = clog2(BIN_W);

  dd_state_t        state;
  dd_state_t        state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;
  logic [BIN_W-1:0] shift_reg;
  logic [ACC_W-1:0] acc;

  // One double-dabble iteration: correct every digit >= 5, then shift the
  // combined {accumulator, shift register} left by one.
  function automatic logic [ACC_W+BIN_W-1:0] dd_step(input logic [ACC_W-1:0] a,
                                                      input logic [BIN_W-1:0] s);
    logic [ACC_W-1:0] adj;
    adj = a;
    for (int d = 0; d < DIGITS + 1; d++) begin
      if (adj[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
    end
    return {adj, s} << 1;
  endfunction

  assign last_bit = (bit_cnt == CNT_W'(BIN_W - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = CONVERT;
      CONVERT: if (last_bit) state_nxt = COMMIT;
      COMMIT:                state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
    done = (state == COMMIT);
  end

  // Bit counter is control: it decides when CONVERT ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (state == IDLE && start) begin
      bit_cnt <= '0;
    end else if (state == CONVERT) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Datapath: no reset, contents are only consumed in COMMIT.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      acc       <= '0;
      shift_reg <= bin_value;
    end else if (state == CONVERT) begin
      {acc, shift_reg} <= dd_step(acc, shift_reg);
    end
  end

  assign bcd_acc = acc;

endmodule

// File: rtl/bcd_scan_driver.sv
// ---------------------------------------------------------------------------
// bcd_scan_driver
// Converts a loaded binary value to BCD, holds it in a display register and
// time-multiplexes the digits onto one bcd/blank pair with a one-hot select.
// Applies leading-zero blanking and shows overflow as a dark panel.
//   clk, rst  : clock, asynchronous active-high reset
//   bin_value : unsigned binary value to display
//   load      : one-cycle strobe, ignored while busy
//   lzb_en    : 1 = blank leading zeros
//   bcd       : digit for the selected position (BCD_DARK on overflow)
//   blank     : 1 = selected digit must be dark
//   digit_sel : one-hot digit common select, bit 0 = least significant
//   busy      : conversion in progress
//   overflow  : last committed value exceeded 10^DIGITS-1
// ---------------------------------------------------------------------------
module bcd_scan_driver
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  bin_value,
  input  logic              load,
  input  logic              lzb_en,
  output logic [3:0]        bcd,
  output logic              blank,
  output logic [DIGITS-1:0] digit_sel,
  output logic              busy,
  output logic              overflow
);

  localparam int ACC_W = (DIGITS + 1) * 4;
  localparam int DSP_W = DIGITS * 4;
  localparam int PRE_W = clog2(SCAN_DIV);
  localparam int IDX_W = clog2(DIGITS);

  logic              conv_start;
  logic              conv_busy;
  logic              conv_done;
  logic [ACC_W-1:0]  conv_acc;

  logic [DSP_W-1:0]  disp_reg;
  logic              disp_vld;

  logic [PRE_W-1:0]  presc;
  logic              presc_tc;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [3:0]        nxt_bcd;
  logic              nxt_blank;

  // True when digits i..DIGITS-1 of the display register are all zero.
  function automatic logic upper_zero(input logic [DSP_W-1:0] d, input int i);
    logic r;
    r = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= i && d[j*4 +: 4] != 4'd0) r = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [3:0] digit_at(input logic [DSP_W-1:0] d, input int i);
    logic [3:0] r;
    r = 4'd0;
    for (int j = 0; j < DIGITS; j++) begin
      if (j == i) r = d[j*4 +: 4];
    end
    return r;
  endfunction

  // load while busy is dropped here; the core also ignores it outside IDLE.
  assign conv_start = load & ~conv_busy;
  assign busy       = conv_busy;

  bin2bcd_dd #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_dd (
    .clk       (clk),
    .rst       (rst),
    .start     (conv_start),
    .bin_value (bin_value),
    .busy      (conv_busy),
    .done      (conv_done),
    .bcd_acc   (conv_acc)
  );

  // Commit stage: display register and overflow update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_reg <= '0;
      disp_vld <= 1'b0;
      overflow <= 1'b0;
    end else if (conv_done) begin
      disp_reg <= conv_acc[DSP_W-1:0];
      disp_vld <= 1'b1;
      overflow <= |conv_acc[ACC_W-1 -: 4];
    end
  end

  assign presc_tc = (presc == PRE_W'(SCAN_DIV - 1));
  assign idx_nxt  = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;

  // Digit content for the position about to be selected.
  always_comb begin
    nxt_bcd   = 4'd0;
    nxt_blank = 1'b1;
    if (!disp_vld) begin
      nxt_blank = 1'b1;
    end else if (overflow) begin
      nxt_bcd   = BCD_DARK;
      nxt_blank = 1'b0;
    end else if (lzb_en && idx_nxt != '0 && upper_zero(disp_reg, int'(idx_nxt))) begin
      nxt_blank = 1'b1;
    end else begin
      nxt_bcd   = digit_at(disp_reg, int'(idx_nxt));
      nxt_blank = 1'b0;
    end
  end

  // Scan stage: select, digit and blank all move on the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      idx       <= '0;
      digit_sel <= {{(DIGITS-1){1'b0}}, 1'b1};
      bcd       <= 4'd0;
      blank     <= 1'b1;
    end else begin
      if (presc_tc) begin
        presc     <= '0;
        idx       <= idx_nxt;
        digit_sel <= {{(DIGITS-1){1'b0}}, 1'b1} << idx_nxt;
        bcd       <= nxt_bcd;
        blank     <= nxt_blank;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
module tb_bcd_scan_driver;

  localparam int DIGITS   = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;

  logic              clk;
  logic              rst;
  logic [BIN_W-1:0]  bin_value;
  logic              load;
  logic              lzb_en;
  logic [3:0]        bcd;
  logic              blank;
  logic [DIGITS-1:0] digit_sel;
  logic              busy;
  logic              overflow;

  int checks = 0;
  int errors = 0;
  int nbusy;

  bcd_scan_driver #(
    .DIGITS   (DIGITS),
    .BIN_W    (BIN_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bin_value (bin_value),
    .load      (load),
    .lzb_en    (lzb_en),
    .bcd       (bcd),
    .blank     (blank),
    .digit_sel (digit_sel),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle load strobe, driven between rising edges.
  task automatic start_load(input logic [BIN_W-1:0] v);
    @(negedge clk);
    bin_value = v;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  // Counts negedge samples with busy=1, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Ensures every digit shown from now on was loaded after the last change.
  task automatic settle();
    repeat (SCAN_DIV + 1) @(negedge clk);
  endtask

  task automatic check_digit(input string tag, input int i, input logic [3:0] exp_bcd,
                             input logic exp_blank, input logic cmp_bcd);
    logic [DIGITS-1:0] exp_sel;
    int w;
    exp_sel = DIGITS'(1) << i;
    w = 0;
    while (digit_sel !== exp_sel && w < 2 * DIGITS * SCAN_DIV + 4) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("%s_d%0d_sel", tag, i), 32'(digit_sel), 32'(exp_sel));
    chk($sformatf("%s_d%0d_blank", tag, i), 32'(blank), 32'(exp_blank));
    if (cmp_bcd) chk($sformatf("%s_d%0d_bcd", tag, i), 32'(bcd), 32'(exp_bcd));
  endtask

  initial begin
    rst       = 1'b1;
    load      = 1'b0;
    bin_value = '0;
    lzb_en    = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_blank", 32'(blank), 32'd1);
    chk("rst_sel", 32'(digit_sel), 32'd1);
    rst = 1'b0;

    // Idle scan with nothing committed: select rotates, everything dark.
    for (int k = 0; k < 2 * DIGITS; k++) begin
      repeat (SCAN_DIV) @(negedge clk);
      chk($sformatf("scan%0d_sel", k), 32'(digit_sel), 32'(1 << ((k + 1) % DIGITS)));
      chk($sformatf("scan%0d_blank", k), 32'(blank), 32'd1);
    end

    // 1234: busy exactly BIN_W+1 cycles, digits 4,3,2,1.
    start_load(14'd1234);
    wait_idle(nbusy);
    chk("b1234_busy_len", 32'(nbusy), 32'd15);
    chk("b1234_overflow", 32'(overflow), 32'd0);
    settle();
    check_digit("v1234", 0, 4'd4, 1'b0, 1'b1);
    check_digit("v1234", 1, 4'd3, 1'b0, 1'b1);
    check_digit("v1234", 2, 4'd2, 1'b0, 1'b1);
    check_digit("v1234", 3, 4'd1, 1'b0, 1'b1);

    // 7 with leading-zero blanking, then without.
    start_load(14'd7);
    wait_idle(nbusy);
    chk("b7_busy_len", 32'(nbusy), 32'd15);
    settle();
    check_digit("v7lzb", 0, 4'd7, 1'b0, 1'b1);
    check_digit("v7lzb", 1, 4'd0, 1'b1, 1'b0);
    check_digit("v7lzb", 2, 4'd0, 1'b1, 1'b0);
    check_digit("v7lzb", 3, 4'd0, 1'b1, 1'b0);
    lzb_en = 1'b0;
    settle();
    check_digit("v7nolzb", 1, 4'd0, 1'b0, 1'b1);
    check_digit("v7nolzb", 2, 4'd0, 1'b0, 1'b1);
    check_digit("v7nolzb", 3, 4'd0, 1'b0, 1'b1);
    check_digit("v7nolzb", 0, 4'd7, 1'b0, 1'b1);

    // 0 with blanking: digit 0 stays lit.
    lzb_en = 1'b1;
    start_load(14'd0);
    wait_idle(nbusy);
    settle();
    check_digit("v0", 0, 4'd0, 1'b0, 1'b1);
    check_digit("v0", 1, 4'd0, 1'b1, 1'b0);
    check_digit("v0", 2, 4'd0, 1'b1, 1'b0);
    check_digit("v0", 3, 4'd0, 1'b1, 1'b0);

    // 16383 overflows four digits: dark panel code on every position.
    start_load(14'd16383);
    wait_idle(nbusy);
    chk("v16383_overflow", 32'(overflow), 32'd1);
    settle();
    for (int i = 0; i < DIGITS; i++) check_digit("v16383", i, 4'hF, 1'b0, 1'b1);

    start_load(14'd9999);
    wait_idle(nbusy);
    chk("v9999_overflow", 32'(overflow), 32'd0);
    settle();
    for (int i = 0; i < DIGITS; i++) check_digit("v9999", i, 4'd9, 1'b0, 1'b1);

    // 5678 with a load pulse of 4321 while busy: the pulse is ignored.
    start_load(14'd5678);
    repeat (3) @(negedge clk);
    chk("v5678_busy_mid", 32'(busy), 32'd1);
    bin_value = 14'd4321;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
    wait_idle(nbusy);
    chk("v5678_done", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("v5678_no_requeue", 32'(busy), 32'd0);
    settle();
    check_digit("v5678", 0, 4'd8, 1'b0, 1'b1);
    check_digit("v5678", 1, 4'd7, 1'b0, 1'b1);
    check_digit("v5678", 2, 4'd6, 1'b0, 1'b1);
    check_digit("v5678", 3, 4'd5, 1'b0, 1'b1);

    // Reset in the middle of converting 1111.
    start_load(14'd1111);
    repeat (5) @(negedge clk);
    chk("v1111_busy_mid", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_blank", 32'(blank), 32'd1);
    chk("midrst_sel", 32'(digit_sel), 32'd1);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < DIGITS; i++) check_digit("post_rst", i, 4'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
